// File: rtl/ir_xmit.sv
// NEC infrared transmitter: sends {addr, ~addr, cmd, ~cmd} as a full NEC frame,
// then repeat frames while tx_repeat is held. Drives a modulated LED pin and a raw envelope.
module ir_xmit #(
  parameter int UNIT_CYCLES  = 15188,
  parameter int CARRIER_DIV  = 711,
  parameter int CARRIER_HIGH = 237,
  parameter int FRAME_UNITS  = 196
) (
  input  logic        clk27,
  input  logic        reset,
  input  logic [15:0] tx_code,
  input  logic        tx_start,
  input  logic        tx_repeat,
  output logic        busy,
  output logic        done,
  output logic        ir_tx,
  output logic        ir_env_n,
  output logic [7:0]  tx_frame_cnt
);

  localparam int UNIT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int CAR_W  = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam logic [UNIT_W-1:0] UNIT_LAST  = UNIT_W'(UNIT_CYCLES - 1);
  localparam logic [CAR_W-1:0]  CAR_LAST   = CAR_W'(CARRIER_DIV - 1);
  localparam logic [7:0]        FRAME_LAST = 8'(FRAME_UNITS - 1);
  localparam logic              CAR_FIRST  = (CARRIER_HIGH > 0);

  typedef enum logic [3:0] {
    IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE,
    STOP_MARK, REP_MARK, REP_SPACE, REP_STOP, GAP
  } state_t;

  state_t              state;
  logic [15:0]         code;
  logic [UNIT_W-1:0]   unit_cnt;
  logic [4:0]          state_units;
  logic [7:0]          frame_units;
  logic [4:0]          bit_idx;
  logic [CAR_W-1:0]    carrier_cnt;

  logic [31:0]         payload;
  logic                cur_bit;
  logic [4:0]          state_len;
  logic                unit_end;
  logic                state_end;
  logic [CAR_W-1:0]    car_next;

  function automatic logic carrier_on(input logic [CAR_W-1:0] c);
    return int'(c) < CARRIER_HIGH;
  endfunction

  // Bit i of payload is the i-th bit on air: address byte first, each byte LSB first.
  assign payload = {~code[7:0], code[7:0], ~code[15:8], code[15:8]};
  assign cur_bit = payload[bit_idx];

  always_comb begin
    state_len = 5'd1;
    case (state)
      LEAD_MARK, REP_MARK: state_len = 5'd16;
      LEAD_SPACE:          state_len = 5'd8;
      REP_SPACE:           state_len = 5'd4;
      BIT_SPACE:           state_len = cur_bit ? 5'd3 : 5'd1;
      default:             state_len = 5'd1;
    endcase
    unit_end = (unit_cnt == UNIT_LAST);
    if (state == IDLE)
      state_end = 1'b0;
    else if (state == GAP)
      state_end = unit_end && (frame_units == FRAME_LAST);
    else
      state_end = unit_end && (state_units == state_len - 5'd1);
    car_next = (carrier_cnt == CAR_LAST) ? '0 : carrier_cnt + CAR_W'(1);
  end

  // Outputs are registered for the cycle being entered, so every branch that
  // changes state also sets the envelope and first carrier sample of the new state.
  always_ff @(posedge clk27) begin
    if (reset) begin
      state        <= IDLE;
      code         <= '0;
      unit_cnt     <= '0;
      state_units  <= '0;
      frame_units  <= '0;
      bit_idx      <= '0;
      carrier_cnt  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      ir_tx        <= 1'b0;
      ir_env_n     <= 1'b1;
      tx_frame_cnt <= '0;
    end else begin
      done        <= 1'b0;
      carrier_cnt <= car_next;
      ir_tx       <= !ir_env_n && carrier_on(car_next);
      if (state != IDLE) begin
        if (unit_end) begin
          unit_cnt    <= '0;
          state_units <= state_units + 5'd1;
          frame_units <= frame_units + 8'd1;
        end else begin
          unit_cnt <= unit_cnt + UNIT_W'(1);
        end
      end
      if (state_end) begin
        state_units <= '0;
        carrier_cnt <= '0;
      end
      case (state)
        IDLE: begin
          if (tx_start) begin
            code         <= tx_code;
            state        <= LEAD_MARK;
            busy         <= 1'b1;
            unit_cnt     <= '0;
            state_units  <= '0;
            frame_units  <= '0;
            carrier_cnt  <= '0;
            tx_frame_cnt <= tx_frame_cnt + 8'd1;
            ir_env_n     <= 1'b0;
            ir_tx        <= CAR_FIRST;
          end
        end
        LEAD_MARK: if (state_end) begin
          state    <= LEAD_SPACE;
          ir_env_n <= 1'b1;
          ir_tx    <= 1'b0;
        end
        LEAD_SPACE: if (state_end) begin
          state    <= BIT_MARK;
          bit_idx  <= '0;
          ir_env_n <= 1'b0;
          ir_tx    <= CAR_FIRST;
        end
        BIT_MARK: if (state_end) begin
          state    <= BIT_SPACE;
          ir_env_n <= 1'b1;
          ir_tx    <= 1'b0;
        end
        BIT_SPACE: if (state_end) begin
          if (bit_idx == 5'd31) begin
            state <= STOP_MARK;
          end else begin
            state   <= BIT_MARK;
            bit_idx <= bit_idx + 5'd1;
          end
          ir_env_n <= 1'b0;
          ir_tx    <= CAR_FIRST;
        end
        STOP_MARK, REP_STOP: if (state_end) begin
          state    <= GAP;
          ir_env_n <= 1'b1;
          ir_tx    <= 1'b0;
        end
        REP_MARK: if (state_end) begin
          state    <= REP_SPACE;
          ir_env_n <= 1'b1;
          ir_tx    <= 1'b0;
        end
        REP_SPACE: if (state_end) begin
          state    <= REP_STOP;
          ir_env_n <= 1'b0;
          ir_tx    <= CAR_FIRST;
        end
        GAP: if (state_end) begin
          if (tx_repeat) begin
            state        <= REP_MARK;
            frame_units  <= '0;
            tx_frame_cnt <= tx_frame_cnt + 8'd1;
            ir_env_n     <= 1'b0;
            ir_tx        <= CAR_FIRST;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_xmit.sv
// Scoreboard bench for ir_xmit: expected envelope segments, payload words and done
// events are queued by the stimulus and checked by an independent monitor.
module tb_ir_xmit;

  localparam int UNIT = 4;

  logic        clk27 = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] tx_code = '0;
  logic        tx_start = 1'b0;
  logic        tx_repeat = 1'b0;
  logic        busy, done, ir_tx, ir_env_n;
  logic [7:0]  tx_frame_cnt;

  ir_xmit #(
    .UNIT_CYCLES(4), .CARRIER_DIV(4), .CARRIER_HIGH(1), .FRAME_UNITS(196)
  ) dut (
    .clk27(clk27), .reset(reset), .tx_code(tx_code), .tx_start(tx_start),
    .tx_repeat(tx_repeat), .busy(busy), .done(done), .ir_tx(ir_tx),
    .ir_env_n(ir_env_n), .tx_frame_cnt(tx_frame_cnt)
  );

  always #5 clk27 = ~clk27;

  typedef struct { logic lvl; int len; } seg_t;
  typedef struct { int dur; int cnt; } done_t;

  seg_t        sb_seg[$];
  logic [31:0] sb_word[$];
  done_t       sb_done[$];

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  logic        m_run_lvl;
  int          m_run_len, m_car_bad, m_nbits, m_cyc, m_busy_t;
  bit          m_skip_high, m_decoding;
  logic        m_prev_busy, m_exp_tx;
  logic [31:0] m_word;
  seg_t        m_es;
  done_t       m_ed;
  logic        ok;
  int          saved_done;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  task automatic pushSeg(input logic lvl, input int len);
    seg_t s;
    s.lvl = lvl;
    s.len = len;
    sb_seg.push_back(s);
  endtask

  task automatic pushDone(input int dur, input int cnt);
    done_t d;
    d.dur = dur;
    d.cnt = cnt;
    sb_done.push_back(d);
  endtask

  // Full frame: 16-unit lead mark, 8-unit lead space, 32 bits, stop mark, optional gap.
  task automatic pushFull(input logic [31:0] word, input int gap);
    pushSeg(1'b0, 16 * UNIT);
    pushSeg(1'b1, 8 * UNIT);
    for (int i = 0; i < 32; i++) begin
      pushSeg(1'b0, UNIT);
      pushSeg(1'b1, word[i] ? 3 * UNIT : UNIT);
    end
    pushSeg(1'b0, UNIT);
    if (gap > 0) pushSeg(1'b1, gap);
    sb_word.push_back(word);
  endtask

  task automatic pushRep(input int gap);
    pushSeg(1'b0, 16 * UNIT);
    pushSeg(1'b1, 4 * UNIT);
    pushSeg(1'b0, UNIT);
    if (gap > 0) pushSeg(1'b1, gap);
  endtask

  task automatic applyStimulus(input logic [15:0] code);
    @(posedge clk27); #1;
    tx_code  = code;
    tx_start = 1'b1;
    @(posedge clk27); #1;
    tx_start = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clk27); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk27);
    #1 reset = 1'b0;
  endtask

  task automatic waitDone(input int limit, output logic found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk27); #1;
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: no done within %0d cycles", limit);
    end
  endtask

  // Monitor: measures envelope runs, carrier phase, decodes bits and checks done timing.
  initial begin
    m_run_lvl = 1'b1; m_run_len = 0; m_car_bad = 0; m_cyc = 0; m_busy_t = 0;
    m_skip_high = 1'b1; m_decoding = 1'b0; m_nbits = 0; m_prev_busy = 1'b0; m_word = '0;
    forever begin
      @(negedge clk27);
      m_cyc++;
      if (reset) begin
        m_run_lvl = 1'b1; m_run_len = 0; m_car_bad = 0;
        m_skip_high = 1'b1; m_decoding = 1'b0; m_prev_busy = 1'b0;
      end else begin
        if (ir_env_n !== m_run_lvl) begin
          if (m_run_lvl && m_skip_high) begin
            m_skip_high = 1'b0;
          end else begin
            if (sb_seg.size() == 0) begin
              checkOutput("seg_unexpected", m_run_len, 0);
            end else begin
              m_es = sb_seg.pop_front();
              checkOutput(m_run_lvl ? "space_len" : "mark_len", m_run_len, m_es.len);
              checkOutput("seg_level", m_run_lvl, m_es.lvl);
            end
            checkOutput(m_run_lvl ? "carrier_space" : "carrier_mark", m_car_bad, 0);
            if (m_run_lvl && m_run_len == 8 * UNIT) begin
              m_decoding = 1'b1;
              m_nbits = 0;
              m_word = '0;
            end else if (m_run_lvl && m_decoding) begin
              m_word[m_nbits] = (m_run_len > 2 * UNIT);
              m_nbits++;
              if (m_nbits == 32) begin
                m_decoding = 1'b0;
                if (sb_word.size() == 0) checkOutput("word_unexpected", m_word, 0);
                else checkOutput("payload", m_word, sb_word.pop_front());
              end
            end
          end
          m_run_lvl = ir_env_n;
          m_run_len = 0;
          m_car_bad = 0;
        end
        m_exp_tx = !m_run_lvl && (m_run_len % 4 == 0);
        if (ir_tx !== m_exp_tx) m_car_bad++;
        m_run_len++;
        if (busy && !m_prev_busy) m_busy_t = m_cyc;
        m_prev_busy = busy;
        if (done) begin
          done_seen++;
          if (sb_done.size() == 0) begin
            checkOutput("done_unexpected", 1, 0);
          end else begin
            m_ed = sb_done.pop_front();
            checkOutput("done_latency", m_cyc - m_busy_t, m_ed.dur);
            checkOutput("frame_cnt_at_done", tx_frame_cnt, m_ed.cnt);
            checkOutput("busy_at_done", busy, 0);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk27);
    #1 reset = 1'b0;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ir_tx", ir_tx, 0);
    checkOutput("rst_env_n", ir_env_n, 1);
    checkOutput("rst_frame_cnt", tx_frame_cnt, 0);

    // Reset and start in the same cycle: reset wins, start is not queued
    @(posedge clk27); #1;
    reset = 1'b1; tx_code = 16'h1234; tx_start = 1'b1;
    @(posedge clk27); #1;
    reset = 1'b0; tx_start = 1'b0;
    checkOutput("rst_start_busy", busy, 0);
    checkOutput("rst_start_env", ir_env_n, 1);
    @(posedge clk27); #1;
    checkOutput("rst_start_busy_later", busy, 0);
    checkOutput("rst_start_cnt", tx_frame_cnt, 0);

    // Full frame 0x1234 -> bytes 12 ED 34 CB
    pushFull(32'hCB34ED12, 0);
    pushDone(784, 1);
    applyStimulus(16'h1234);
    checkOutput("start_busy", busy, 1);
    checkOutput("start_env", ir_env_n, 0);
    checkOutput("start_ir_tx", ir_tx, 1);
    waitDone(1000, ok);
    checkOutput("full_frame_cnt", tx_frame_cnt, 1);
    doReset();

    // Full frame plus two repeat frames
    pushFull(32'hCB34ED12, 784 - 121 * UNIT);
    pushRep(784 - 21 * UNIT);
    pushRep(0);
    pushDone(3 * 784, 3);
    tx_repeat = 1'b1;
    applyStimulus(16'h1234);
    repeat (2 * 784 + 300) @(posedge clk27);
    #1 tx_repeat = 1'b0;
    waitDone(1000, ok);
    checkOutput("repeat_frame_cnt", tx_frame_cnt, 3);
    doReset();

    // Start while busy is ignored; start on the done cycle begins the next frame
    pushFull(32'hCB34ED12, 784 - 121 * UNIT + 1);
    pushDone(784, 1);
    pushFull(32'h5AA5A55A, 0);
    pushDone(784, 2);
    applyStimulus(16'h1234);
    repeat (97) @(posedge clk27);
    applyStimulus(16'hFFFF);
    waitDone(1000, ok);
    if (ok) begin
      tx_code  = 16'h5AA5;
      tx_start = 1'b1;
      @(posedge clk27); #1;
      tx_start = 1'b0;
      checkOutput("restart_busy", busy, 1);
      checkOutput("restart_env", ir_env_n, 0);
    end
    waitDone(1000, ok);
    doReset();

    // Reset mid-frame: immediate reset values and no done
    pushFull(32'hCB34ED12, 0);
    applyStimulus(16'h1234);
    repeat (298) @(posedge clk27);
    #1 reset = 1'b1;
    @(posedge clk27); #1;
    reset = 1'b0;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_env", ir_env_n, 1);
    checkOutput("midrst_ir_tx", ir_tx, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_cnt", tx_frame_cnt, 0);
    sb_seg.delete();
    sb_word.delete();
    saved_done = done_seen;
    repeat (1000) @(posedge clk27);
    #1;
    checkOutput("midrst_no_done", done_seen, saved_done);

    checkOutput("seg_left", sb_seg.size(), 0);
    checkOutput("word_left", sb_word.size(), 0);
    checkOutput("done_left", sb_done.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
